// File: rtl/parity_pipe_if.sv
// Handshake and data bundle for parity_pipe; the DUT takes the slave modport.
// Extra error-check signals exist only when PARITY_PIPE_CHECK_EN is defined.
interface parity_pipe_if #(
  parameter int DATA_WIDTH = 256,
  parameter int LANE_WIDTH = 8
);
  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int CNT_W     = $clog2(DATA_WIDTH + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_odd;
  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_LANES-1:0]  out_lane_par;
  logic                  out_word_par;
  logic [CNT_W-1:0]      out_ones;
`ifdef PARITY_PIPE_CHECK_EN
  logic [NUM_LANES-1:0]  in_exp_par;
  logic [NUM_LANES-1:0]  out_err_lanes;
  logic [15:0]           err_cnt;
  logic                  err_clr;

  modport master (
    output in_valid, in_data, in_odd, out_ready, in_exp_par, err_clr,
    input  in_ready, out_valid, out_lane_par, out_word_par, out_ones,
           out_err_lanes, err_cnt
  );
  modport slave (
    input  in_valid, in_data, in_odd, out_ready, in_exp_par, err_clr,
    output in_ready, out_valid, out_lane_par, out_word_par, out_ones,
           out_err_lanes, err_cnt
  );
`else
  modport master (
    output in_valid, in_data, in_odd, out_ready,
    input  in_ready, out_valid, out_lane_par, out_word_par, out_ones
  );
  modport slave (
    input  in_valid, in_data, in_odd, out_ready,
    output in_ready, out_valid, out_lane_par, out_word_par, out_ones
  );
`endif
endinterface

// File: rtl/parity_pipe.sv
// Two-stage valid/ready pipeline: per-lane parity, word parity and popcount.
// Optional lane-parity checker and error counter under PARITY_PIPE_CHECK_EN.
module parity_pipe #(
  parameter int DATA_WIDTH = 256,
  parameter int LANE_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  parity_pipe_if.slave  bus
);
  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int CNT_W     = $clog2(DATA_WIDTH + 1);
  localparam int LCW       = $clog2(LANE_WIDTH + 1);

  logic                           s1_valid;
  logic [NUM_LANES-1:0]           s1_xor;
  logic [NUM_LANES-1:0][LCW-1:0]  s1_cnt;
  logic                           s1_odd;
  logic                           s2_valid;
  logic [NUM_LANES-1:0]           s2_lane_par;
  logic                           s2_word_par;
  logic [CNT_W-1:0]               s2_ones;

  logic                           s1_adv;
  logic                           s2_adv;
  logic [NUM_LANES-1:0]           lane_xor;
  logic [NUM_LANES-1:0][LCW-1:0]  lane_cnt;
  logic [CNT_W-1:0]               ones_sum;

  assign s2_adv      = enable & (~s2_valid | bus.out_ready);
  assign s1_adv      = enable & (~s1_valid | s2_adv);
  assign bus.in_ready = s1_adv;

  always_comb begin
    lane_xor = '0;
    lane_cnt = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_xor[k] = ^bus.in_data[k*LANE_WIDTH +: LANE_WIDTH];
      for (int b = 0; b < LANE_WIDTH; b++) begin
        lane_cnt[k] = lane_cnt[k] + LCW'(bus.in_data[k*LANE_WIDTH + b]);
      end
    end
  end

  always_comb begin
    ones_sum = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      ones_sum = ones_sum + CNT_W'(s1_cnt[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_xor   <= '0;
      s1_cnt   <= '0;
      s1_odd   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      s1_xor   <= lane_xor;
      s1_cnt   <= lane_cnt;
      s1_odd   <= bus.in_odd;
    end
  end

  // Odd mode is folded in here so stage 1 stays a pure reduction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      s2_lane_par <= '0;
      s2_word_par <= 1'b0;
      s2_ones     <= '0;
    end else if (s2_adv) begin
      s2_valid    <= s1_valid;
      s2_lane_par <= s1_xor ^ {NUM_LANES{s1_odd}};
      s2_word_par <= (^s1_xor) ^ s1_odd;
      s2_ones     <= ones_sum;
    end
  end

  assign bus.out_valid    = s2_valid;
  assign bus.out_lane_par = s2_lane_par;
  assign bus.out_word_par = s2_word_par;
  assign bus.out_ones     = s2_ones;

`ifdef PARITY_PIPE_CHECK_EN
  logic [NUM_LANES-1:0] s1_exp;
  logic [NUM_LANES-1:0] s2_err;
  logic [15:0]          err_cnt_q;
  logic                 out_pop;

  assign out_pop = s2_adv & s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_exp <= '0;
      s2_err <= '0;
    end else begin
      if (s1_adv) s1_exp <= bus.in_exp_par;
      if (s2_adv) s2_err <= (s1_xor ^ {NUM_LANES{s1_odd}}) ^ s1_exp;
    end
  end

  // Clear has priority; the counter saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (bus.err_clr) begin
      err_cnt_q <= '0;
    end else if (out_pop && (|s2_err) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.out_err_lanes = s2_err;
  assign bus.err_cnt       = err_cnt_q;
`endif

endmodule

// File: doc/parity_pipe.md
Name: parity_pipe

Overview:
- Parametrised, pipelined parity generator for the Risc_BMI_ALU datapath.
- Splits a DATA_WIDTH word into LANE_WIDTH lanes and produces:
  - one parity bit per lane,
  - a whole-word parity bit,
  - a population count.
- Two registered stages with valid/ready handshake on both sides, so it sits between the operand bus and ALU writeback without blocking other units.
- Even/odd parity is selected per transaction; a global enable freezes the pipe.

Parameters:
- DATA_WIDTH, 256, input word width; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, lane width for per-lane parity; power of two, 1..DATA_WIDTH.
- NUM_LANES, DATA_WIDTH/LANE_WIDTH, derived lane count; not to be overridden.
- CNT_W, $clog2(DATA_WIDTH+1), popcount width (9 at default).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  global advance; 0 holds all pipeline state and blocks acceptance
- in_valid  in  1  input word valid
- in_ready  out  1  pipe can accept a word this cycle
- in_data  in  DATA_WIDTH  word to process
- in_odd  in  1  0 = even parity, 1 = odd parity; captured with in_data
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_lane_par  out  NUM_LANES  bit k = parity of in_data[k*LANE_WIDTH +: LANE_WIDTH], XOR in_odd
- out_word_par  out  1  XOR of all DATA_WIDTH bits, XOR in_odd
- out_ones  out  CNT_W  number of 1 bits in the word

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid = s2_valid = 0. out_valid = 0; out_lane_par, out_word_par, out_ones all 0. All data registers cleared.
- Stage 1 (S1) registers per-lane XOR results, per-lane popcounts and in_odd.
- Stage 2 (S2) registers the lane-parity vector with in_odd applied, the XOR-reduction of lane parities with in_odd applied, and the sum of lane popcounts. S2 drives the outputs directly.
- Latency: a word accepted in cycle N (in_valid & in_ready) appears with out_valid = 1 in cycle N+2, provided enable stays high and the pipe is not stalled.
- Throughput: one word per cycle when out_ready is held high.
- Advance conditions (all gated by enable):
  - s2_adv = enable & (!s2_valid | out_ready)
  - s1_adv = enable & (!s1_valid | s2_adv)
  - in_ready = s1_adv (combinational)
- S2 load: when s2_adv, s2 <= s1 contents and s2_valid <= s1_valid.
- S1 load: when s1_adv, s1 <= new input and s1_valid <= in_valid.
- Output holds stable while out_valid & !out_ready; no data is dropped or duplicated.
- enable = 0:
  - in_ready = 0; all state held.
  - out_valid and its data keep their values.
  - A handshake on out_ready during enable = 0 does not pop; the consumer must see enable high for the transfer to complete.
- Odd mode inverts every lane bit and the word bit. out_ones is unaffected by in_odd.
- Boundaries:
  - All-zero word, even mode: parity = 0, ones = 0.
  - All-ones word: ones = DATA_WIDTH, which fits CNT_W.
  - LANE_WIDTH = DATA_WIDTH: a single lane, and out_lane_par[0] equals out_word_par.
- Back-pressure: with out_ready = 0, the pipe holds exactly two words, then in_ready drops. When out_ready rises, the S2 and S1 words drain in order.
- Reset mid-operation flushes both stages immediately; nothing in flight is emitted after rst_n deasserts.

Optional Feature:
- Macro: PARITY_PIPE_CHECK_EN.
- Defined, adds the following ports:
  - in_exp_par (in, NUM_LANES): expected lane parity, captured with in_data.
  - out_err_lanes (out, NUM_LANES): out_lane_par XOR captured expectation.
  - err_cnt (out, 16): saturating count of output transfers with any error lane set; holds at 16'hFFFF.
  - err_clr (in, 1): synchronous clear of err_cnt; clear wins over a simultaneous increment.
  - err_cnt resets to 0.
- Not defined: these ports and their registers are absent; the remaining behaviour is identical.

Test Plan:
- Reset, then a single word 256'h0, even mode, out_ready = 1 -> out_valid exactly 2 cycles after accept; lane_par = 0, word_par = 0, ones = 0.
- Word 256'h01 with in_odd = 0, then the same word with in_odd = 1, back-to-back -> first result: lane_par = 32'h00000001, word_par = 1, ones = 1. Second result: lane_par = 32'hFFFFFFFE, word_par = 0, ones = 1, on consecutive cycles.
- All-ones word, even mode -> lane_par = 0, word_par = 0, ones = 256.
- Stream of 5 words with out_ready held 0 -> in_ready falls after 2 accepts. Raising out_ready delivers the words in order with no loss or duplication.
- enable driven 0 for 3 cycles mid-stream -> outputs frozen and in_ready = 0. On enable = 1 the stream resumes with results matching a model.
- With PARITY_PIPE_CHECK_EN: in_exp_par = 0 on word 256'h0101 -> out_err_lanes = 32'h00000003 and err_cnt increments to 1. err_clr pulsed in the same cycle as a further error -> err_cnt = 0.
